// File: rtl/load_store_unit.sv
// Load/store unit: runs one RISC-V data access over a req/gnt/rvalid bus and
// returns aligned, extended load data for register write-back.
module load_store_unit #(
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned CNT_W   = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_rd,
    input  logic        mem_wr,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic [31:0] ld_data,
    output logic        ld_valid,
    output logic        acc_fault,
    output logic        bus_timeout,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_gnt,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE
    } state_e;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              bus_req_q, bus_req_d;
    logic              bus_we_q, bus_we_d;
    logic [31:0]       bus_addr_q, bus_addr_d;
    logic [3:0]        bus_be_q, bus_be_d;
    logic [31:0]       bus_wdata_q, bus_wdata_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [1:0]        off_q, off_d;
    logic [31:0]       ld_data_q, ld_data_d;
    logic              ld_valid_q, ld_valid_d;
    logic              acc_fault_q, acc_fault_d;
    logic              bus_timeout_q, bus_timeout_d;

    logic              fault_c;
    logic [3:0]        be_c;
    logic [31:0]       wdata_c;
    logic [31:0]       lane_c;
    logic [31:0]       ext_c;

    // Access legality, byte enables and lane-replicated store data
    always_comb begin
        fault_c = (mem_rd & mem_wr)
                | (mem_rd & ((funct3 == 3'b011) | (funct3 == 3'b110) | (funct3 == 3'b111)))
                | (mem_wr & (funct3 >= 3'b011))
                | ((funct3[1:0] == 2'b01) & addr[0])
                | ((funct3 == 3'b010) & (addr[1:0] != 2'b00));
        be_c    = 4'b1111;
        wdata_c = 32'h0;
        if (mem_wr) begin
            case (funct3[1:0])
                2'b00: begin
                    be_c    = 4'b0001 << addr[1:0];
                    wdata_c = {4{wdata[7:0]}};
                end
                2'b01: begin
                    be_c    = 4'b0011 << {addr[1], 1'b0};
                    wdata_c = {2{wdata[15:0]}};
                end
                default: begin
                    be_c    = 4'b1111;
                    wdata_c = wdata;
                end
            endcase
        end
    end

    // Select the addressed lane of the read word and extend it
    always_comb begin
        lane_c = bus_rdata >> {off_q, 3'b000};
        case (funct3_q)
            3'b000:  ext_c = {{24{lane_c[7]}}, lane_c[7:0]};
            3'b001:  ext_c = {{16{lane_c[15]}}, lane_c[15:0]};
            3'b100:  ext_c = {24'h0, lane_c[7:0]};
            3'b101:  ext_c = {16'h0, lane_c[15:0]};
            default: ext_c = bus_rdata;
        endcase
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        bus_req_d     = bus_req_q;
        bus_we_d      = bus_we_q;
        bus_addr_d    = bus_addr_q;
        bus_be_d      = bus_be_q;
        bus_wdata_d   = bus_wdata_q;
        funct3_d      = funct3_q;
        off_d         = off_q;
        ld_data_d     = ld_data_q;
        ld_valid_d    = 1'b0;
        acc_fault_d   = 1'b0;
        bus_timeout_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (mem_rd | mem_wr) begin
                    if (fault_c) begin
                        acc_fault_d = 1'b1;
                        state_d     = S_DONE;
                    end else begin
                        bus_req_d   = 1'b1;
                        bus_we_d    = mem_wr;
                        bus_addr_d  = {addr[31:2], 2'b00};
                        bus_be_d    = be_c;
                        bus_wdata_d = wdata_c;
                        funct3_d    = funct3;
                        off_d       = addr[1:0];
                        cnt_d       = '0;
                        state_d     = S_REQ;
                    end
                end
            end
            S_REQ: begin
                if (bus_gnt) begin
                    bus_req_d = 1'b0;
                    cnt_d     = '0;
                    state_d   = bus_we_q ? S_DONE : S_WAIT;
                end else if (cnt_q == CNT_MAX) begin
                    bus_req_d     = 1'b0;
                    bus_timeout_d = 1'b1;
                    ld_data_d     = 32'h0;
                    state_d       = S_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_WAIT: begin
                if (bus_rvalid) begin
                    ld_data_d  = ext_c;
                    ld_valid_d = 1'b1;
                    state_d    = S_DONE;
                end else if (cnt_q == CNT_MAX) begin
                    bus_timeout_d = 1'b1;
                    ld_data_d     = 32'h0;
                    state_d       = S_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            bus_req_q     <= 1'b0;
            bus_we_q      <= 1'b0;
            bus_addr_q    <= 32'h0;
            bus_be_q      <= 4'h0;
            bus_wdata_q   <= 32'h0;
            funct3_q      <= 3'b000;
            off_q         <= 2'b00;
            ld_data_q     <= 32'h0;
            ld_valid_q    <= 1'b0;
            acc_fault_q   <= 1'b0;
            bus_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            bus_req_q     <= bus_req_d;
            bus_we_q      <= bus_we_d;
            bus_addr_q    <= bus_addr_d;
            bus_be_q      <= bus_be_d;
            bus_wdata_q   <= bus_wdata_d;
            funct3_q      <= funct3_d;
            off_q         <= off_d;
            ld_data_q     <= ld_data_d;
            ld_valid_q    <= ld_valid_d;
            acc_fault_q   <= acc_fault_d;
            bus_timeout_q <= bus_timeout_d;
        end
    end

    // Core stall; forced low while reset is asserted so outputs drop immediately
    assign stall = rst_n & (((state_q == S_IDLE) & (mem_rd | mem_wr))
                          | (state_q == S_REQ) | (state_q == S_WAIT));

    assign ld_data     = ld_data_q;
    assign ld_valid    = ld_valid_q;
    assign acc_fault   = acc_fault_q;
    assign bus_timeout = bus_timeout_q;
    assign bus_req     = bus_req_q;
    assign bus_we      = bus_we_q;
    assign bus_addr    = bus_addr_q;
    assign bus_be      = bus_be_q;
    assign bus_wdata   = bus_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases plus randomized
// accesses compared against a transaction-level reference model.
module tb_load_store_unit;

    localparam int unsigned TO = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_rd = 1'b0;
    logic        mem_wr = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic        stall;
    logic [31:0] ld_data;
    logic        ld_valid;
    logic        acc_fault;
    logic        bus_timeout;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_gnt = 1'b0;
    logic        bus_rvalid = 1'b0;
    logic [31:0] bus_rdata = 32'h0;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] exp_ld = 32'h0;

    load_store_unit #(.TIMEOUT(TO), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .funct3(funct3), .addr(addr), .wdata(wdata),
        .stall(stall), .ld_data(ld_data), .ld_valid(ld_valid), .acc_fault(acc_fault),
        .bus_timeout(bus_timeout), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_be(bus_be), .bus_wdata(bus_wdata), .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid),
        .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Outputs that must be low whenever the unit is idle
    task automatic check_quiet(input string tag);
        check_eq({tag, "_ld_valid"}, 32'(ld_valid), 32'd0);
        check_eq({tag, "_acc_fault"}, 32'(acc_fault), 32'd0);
        check_eq({tag, "_timeout"}, 32'(bus_timeout), 32'd0);
        check_eq({tag, "_bus_req"}, 32'(bus_req), 32'd0);
    endtask

    // One access: gnt_cyc / rv_cyc give the 1-based cycle of the handshake
    // within REQ / WAIT; 0 or values beyond TO mean the handshake never comes.
    task automatic run_op(input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd,
                          input int gnt_cyc, input int rv_cyc, input logic [31:0] rdat);
        logic        fault, is_ld, to, done;
        int          exp_req, exp_wait, n_req, n_wait, n_stall, sz, off;
        logic [31:0] ebe, ewd, lane;

        is_ld = rd && !wr;
        off   = int'(a[1:0]);
        sz    = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        fault = (rd && wr) || (rd && (f3 == 3 || f3 == 6 || f3 == 7)) || (wr && f3 >= 3)
              || (sz == 2 && (off % 2) != 0) || (f3 == 2 && off != 0);
        exp_req = 0; exp_wait = 0; to = 1'b0;
        if (!fault) begin
            if (gnt_cyc >= 1 && gnt_cyc <= int'(TO)) exp_req = gnt_cyc;
            else begin exp_req = int'(TO); to = 1'b1; end
            if (is_ld && !to) begin
                if (rv_cyc >= 1 && rv_cyc <= int'(TO)) exp_wait = rv_cyc;
                else begin exp_wait = int'(TO); to = 1'b1; end
            end
        end
        ebe = (is_ld || sz == 4) ? 32'd15 : (sz == 1) ? (32'd1 << off) : (32'd3 << off);
        ewd = (sz == 1) ? (wd & 32'hFF) * 32'h01010101 :
              (sz == 2) ? (wd & 32'hFFFF) * 32'h00010001 : wd;
        lane = rdat >> (8 * off);
        if (sz == 1) begin
            lane = lane & 32'hFF;
            if (f3 < 4 && lane >= 32'h80) lane = lane | 32'hFFFFFF00;
        end else if (sz == 2) begin
            lane = lane & 32'hFFFF;
            if (f3 < 4 && lane >= 32'h8000) lane = lane | 32'hFFFF0000;
        end

        @(negedge clk);
        mem_rd = rd; mem_wr = wr; funct3 = f3; addr = a; wdata = wd;
        bus_gnt = 1'b0; bus_rvalid = 1'b0;
        #1;
        check_eq("idle_stall", 32'(stall), 32'd1);
        check_eq("idle_bus_req", 32'(bus_req), 32'd0);
        n_req = 0; n_wait = 0; n_stall = 1; done = 1'b0;
        for (int c = 0; c < 200 && !done; c++) begin
            @(negedge clk);
            if (!stall) begin
                done = 1'b1;
            end else begin
                n_stall++;
                if (bus_req) begin
                    n_req++;
                    check_eq("bus_addr", bus_addr, {a[31:2], 2'b00});
                    check_eq("bus_we", 32'(bus_we), 32'(wr));
                    check_eq("bus_be", 32'(bus_be), ebe);
                    if (wr) check_eq("bus_wdata", bus_wdata, ewd);
                    bus_gnt    = (n_req == gnt_cyc);
                    bus_rvalid = 1'b0;
                end else begin
                    n_wait++;
                    bus_gnt    = 1'($urandom_range(0, 1));
                    bus_rvalid = (n_wait == rv_cyc);
                    bus_rdata  = bus_rvalid ? rdat : $urandom;
                end
            end
        end
        if (!done) begin
            check_eq("op_cycle_bound", 32'd0, 32'd1);
        end else begin
            check_eq("stall_cycles", 32'(n_stall), 32'(1 + exp_req + exp_wait));
            check_eq("req_cycles", 32'(n_req), 32'(exp_req));
            check_eq("wait_cycles", 32'(n_wait), 32'(exp_wait));
            check_eq("acc_fault", 32'(acc_fault), 32'(fault));
            check_eq("bus_timeout", 32'(bus_timeout), 32'(to));
            check_eq("ld_valid", 32'(ld_valid), 32'(is_ld && !fault && !to));
            check_eq("done_bus_req", 32'(bus_req), 32'd0);
            if (is_ld && !fault && !to) exp_ld = lane;
            if (to) exp_ld = 32'h0;
            check_eq("ld_data", ld_data, exp_ld);
        end
        mem_rd = 1'b0; mem_wr = 1'b0; bus_gnt = 1'b0; bus_rvalid = 1'b0;
        @(negedge clk);
        check_quiet("after");
        check_eq("after_stall", 32'(stall), 32'd0);
    endtask

    initial begin
        logic        rd, wr;
        logic [2:0]  f3;
        logic [31:0] a;
        int          sel, g, r;

        // Reset state
        #12;
        check_quiet("reset");
        check_eq("reset_stall", 32'(stall), 32'd0);
        check_eq("reset_ld_data", ld_data, 32'h0);
        check_eq("reset_bus_addr", bus_addr, 32'h0);
        check_eq("reset_bus_be", 32'(bus_be), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed cases
        run_op(1'b0, 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 3, 0, 32'h0);
        run_op(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 1, 2, 32'h80112233);
        run_op(1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 2, 1, 32'h80112233);
        run_op(1'b0, 1'b1, 3'b001, 32'h102, 32'h00001234, 1, 0, 32'h0);
        run_op(1'b1, 1'b0, 3'b101, 32'h102, 32'h0, 1, 3, 32'hBEEF0000);
        run_op(1'b1, 1'b0, 3'b010, 32'h101, 32'h0, 1, 1, 32'h0);
        run_op(1'b1, 1'b0, 3'b010, 32'h200, 32'h0, 1, 1, 32'h12345678);
        run_op(1'b1, 1'b0, 3'b010, 32'h204, 32'h0, 1, 0, 32'h0);

        // Late handshakes after the timeout are dropped
        bus_rvalid = 1'b1; bus_gnt = 1'b1; bus_rdata = 32'hCAFEF00D;
        @(negedge clk);
        check_quiet("late_rvalid");
        check_eq("late_ld_data", ld_data, 32'h0);
        bus_rvalid = 1'b0; bus_gnt = 1'b0;

        // Store whose grant never arrives times out in REQ
        run_op(1'b0, 1'b1, 3'b000, 32'h301, 32'h000000A5, 0, 0, 32'h0);

        // Reset asserted mid-WAIT
        @(negedge clk);
        mem_rd = 1'b1; funct3 = 3'b010; addr = 32'h400;
        @(negedge clk);
        bus_gnt = 1'b1;
        @(negedge clk);
        bus_gnt = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_eq("rst_bus_req", 32'(bus_req), 32'd0);
        check_eq("rst_stall", 32'(stall), 32'd0);
        mem_rd = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_quiet("post_rst");
        check_eq("post_rst_stall", 32'(stall), 32'd0);
        exp_ld = 32'h0;
        @(negedge clk);
        check_quiet("post_rst2");

        // Randomized accesses
        for (int i = 0; i < 80; i++) begin
            sel = int'($urandom_range(0, 9));
            rd  = (sel == 0) || (sel < 5);
            wr  = (sel == 0) || (sel >= 5);
            f3  = 3'($urandom_range(0, 7));
            a   = $urandom;
            if ($urandom_range(0, 3) != 0) a[1:0] = (f3[1:0] == 2'd2) ? 2'b00 :
                                                   (f3[1:0] == 2'd1) ? {a[1], 1'b0} : a[1:0];
            g = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 4));
            r = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 4));
            run_op(rd, wr, f3, a, $urandom, g, r, $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
